// File: rtl/global_buffer_bank.sv
// Global buffer bank: single-port word store split into weight, activation
// and output regions. Instructions load words into a region (appending at a
// per-region offset) or stream activation words back out, one per cycle.
module global_buffer_bank #(
  parameter int DATA_SIZE       = 8,
  parameter int INTERFACE_DEPTH = 16,
  parameter int BUF_DEPTH       = 64,
  parameter int ADDR_WIDTH      = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [3:0]                           instr_i,
  input  logic                                 instr_valid_i,
  input  logic [15:0]                          instr_len_i,
  output logic                                 instr_ready_o,
  input  logic [ADDR_WIDTH-1:0]                weight_start_addr_i,
  input  logic [ADDR_WIDTH-1:0]                activation_start_addr_i,
  input  logic [ADDR_WIDTH-1:0]                output_start_addr_i,
  input  logic [DATA_SIZE*INTERFACE_DEPTH-1:0] wr_data_i,
  input  logic                                 wr_en_i,
  output logic                                 wr_ready_o,
  output logic [DATA_SIZE*INTERFACE_DEPTH-1:0] rd_data_o,
  output logic                                 rd_data_valid_o,
  output logic                                 done_o
);

  localparam int IW = DATA_SIZE * INTERFACE_DEPTH;
  localparam int AW = $clog2(BUF_DEPTH);

  localparam logic [3:0] OP_POINTER_RESET   = 4'd1;
  localparam logic [3:0] OP_LOAD_WEIGHT     = 4'd2;
  localparam logic [3:0] OP_LOAD_ACTIVATION = 4'd3;
  localparam logic [3:0] OP_LOAD_OUTPUT     = 4'd4;
  localparam logic [3:0] OP_READ_ACTIVATION = 4'd5;

  localparam logic [1:0] REG_W = 2'd0;
  localparam logic [1:0] REG_A = 2'd1;
  localparam logic [1:0] REG_O = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_READ} state_t;

  state_t          state_q, state_d;
  logic [15:0]     count_q, count_d;
  logic [AW-1:0]   base_q, base_d;
  logic [1:0]      region_q, region_d;
  logic [AW-1:0]   w_ptr_q, w_ptr_d;
  logic [AW-1:0]   a_ptr_q, a_ptr_d;
  logic [AW-1:0]   o_ptr_q, o_ptr_d;
  logic [AW-1:0]   a_rd_ptr_q, a_rd_ptr_d;
  logic            done_q, done_d;
  logic            rd_valid_q, rd_valid_d;
  logic [IW-1:0]   rd_data_q, rd_data_d;
  logic [IW-1:0]   mem_q [BUF_DEPTH];

  logic            wr_fire;
  logic [AW-1:0]   region_ptr;
  logic [AW-1:0]   wr_addr;
  logic [AW-1:0]   rd_addr;

  // Only the low AW bits of each base address select a word.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{weight_start_addr_i[ADDR_WIDTH-1:AW],
                              activation_start_addr_i[ADDR_WIDTH-1:AW],
                              output_start_addr_i[ADDR_WIDTH-1:AW]};

  assign region_ptr = (region_q == REG_W) ? w_ptr_q :
                      (region_q == REG_A) ? a_ptr_q : o_ptr_q;
  assign wr_addr    = base_q + region_ptr;
  assign rd_addr    = base_q + a_rd_ptr_q;

  assign instr_ready_o   = (state_q == S_IDLE);
  assign wr_ready_o      = (state_q == S_LOAD);
  assign rd_data_o       = rd_data_q;
  assign rd_data_valid_o = rd_valid_q;
  assign done_o          = done_q;

  // Next-state: instruction decode, write acceptance, read issue.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    base_d     = base_q;
    region_d   = region_q;
    w_ptr_d    = w_ptr_q;
    a_ptr_d    = a_ptr_q;
    o_ptr_d    = o_ptr_q;
    a_rd_ptr_d = a_rd_ptr_q;
    done_d     = 1'b0;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    wr_fire    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (instr_valid_i) begin
          case (instr_i)
            OP_POINTER_RESET: begin
              w_ptr_d    = '0;
              a_ptr_d    = '0;
              o_ptr_d    = '0;
              a_rd_ptr_d = '0;
            end
            OP_LOAD_WEIGHT, OP_LOAD_ACTIVATION, OP_LOAD_OUTPUT: begin
              if (instr_i == OP_LOAD_WEIGHT) begin
                region_d = REG_W;
                base_d   = weight_start_addr_i[AW-1:0];
              end else if (instr_i == OP_LOAD_ACTIVATION) begin
                region_d = REG_A;
                base_d   = activation_start_addr_i[AW-1:0];
              end else begin
                region_d = REG_O;
                base_d   = output_start_addr_i[AW-1:0];
              end
              count_d = instr_len_i;
              if (instr_len_i == 16'd0) done_d = 1'b1;
              else                      state_d = S_LOAD;
            end
            OP_READ_ACTIVATION: begin
              base_d  = activation_start_addr_i[AW-1:0];
              count_d = instr_len_i;
              if (instr_len_i == 16'd0) done_d = 1'b1;
              else                      state_d = S_READ;
            end
            default: ;
          endcase
        end
      end
      S_LOAD: begin
        if (wr_en_i) begin
          wr_fire = 1'b1;
          case (region_q)
            REG_W:   w_ptr_d = w_ptr_q + AW'(1);
            REG_A:   a_ptr_d = a_ptr_q + AW'(1);
            default: o_ptr_d = o_ptr_q + AW'(1);
          endcase
          count_d = count_q - 16'd1;
          if (count_q == 16'd1) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      S_READ: begin
        // Data lands in rd_data_q next cycle; done lines up with the last word.
        rd_valid_d = 1'b1;
        rd_data_d  = mem_q[rd_addr];
        a_rd_ptr_d = a_rd_ptr_q + AW'(1);
        count_d    = count_q - 16'd1;
        if (count_q == 16'd1) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and read-port registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      base_q     <= '0;
      region_q   <= REG_W;
      w_ptr_q    <= '0;
      a_ptr_q    <= '0;
      o_ptr_q    <= '0;
      a_rd_ptr_q <= '0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      base_q     <= base_d;
      region_q   <= region_d;
      w_ptr_q    <= w_ptr_d;
      a_ptr_q    <= a_ptr_d;
      o_ptr_q    <= o_ptr_d;
      a_rd_ptr_q <= a_rd_ptr_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Storage array: not reset, so contents survive a reset.
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_addr] <= wr_data_i;
  end

endmodule

// File: tb/tb_global_buffer_bank.sv
// Testbench for global_buffer_bank: directed scenarios plus randomized
// loads/reads checked against an array-based model of the buffer.
module tb_global_buffer_bank;

  localparam int DEPTH = 64;

  logic         clk;
  logic         rst;
  logic [3:0]   instr_i;
  logic         instr_valid_i;
  logic [15:0]  instr_len_i;
  logic         instr_ready_o;
  logic [31:0]  weight_start_addr_i;
  logic [31:0]  activation_start_addr_i;
  logic [31:0]  output_start_addr_i;
  logic [127:0] wr_data_i;
  logic         wr_en_i;
  logic         wr_ready_o;
  logic [127:0] rd_data_o;
  logic         rd_data_valid_o;
  logic         done_o;

  global_buffer_bank dut (
    .clk                     (clk),
    .rst                     (rst),
    .instr_i                 (instr_i),
    .instr_valid_i           (instr_valid_i),
    .instr_len_i             (instr_len_i),
    .instr_ready_o           (instr_ready_o),
    .weight_start_addr_i     (weight_start_addr_i),
    .activation_start_addr_i (activation_start_addr_i),
    .output_start_addr_i     (output_start_addr_i),
    .wr_data_i               (wr_data_i),
    .wr_en_i                 (wr_en_i),
    .wr_ready_o              (wr_ready_o),
    .rd_data_o               (rd_data_o),
    .rd_data_valid_o         (rd_data_valid_o),
    .done_o                  (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: word contents, which words are known, region offsets.
  logic [127:0] mem_m [DEPTH];
  bit           mem_v [DEPTH];
  int           wp [3];
  int           rdp;
  logic [127:0] fixed_q [$];

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic issue(input logic [3:0] op, input int len, input int wb, input int ab, input int ob);
    instr_i                 = op;
    instr_len_i             = 16'(len);
    weight_start_addr_i     = wb;
    activation_start_addr_i = ab;
    output_start_addr_i     = ob;
    instr_valid_i           = 1'b1;
    check("instr_ready_at_issue", instr_ready_o, 1'b1);
    tick();
    instr_valid_i           = 1'b0;
    instr_i                 = 4'd0;
    // Base inputs changing after acceptance must have no effect.
    weight_start_addr_i     = $urandom;
    activation_start_addr_i = $urandom;
    output_start_addr_i     = $urandom;
  endtask

  task automatic pointer_reset();
    issue(4'd1, 0, $urandom, $urandom, $urandom);
    check("ptr_reset_no_done", done_o, 1'b0);
    check("ptr_reset_idle", instr_ready_o, 1'b1);
    wp[0] = 0; wp[1] = 0; wp[2] = 0; rdp = 0;
  endtask

  task automatic do_load(input int region, input int len, input int base, input bit gaps);
    logic [127:0] d;
    int a;
    issue(4'(2 + region), len,
          (region == 0) ? base : int'($urandom),
          (region == 1) ? base : int'($urandom),
          (region == 2) ? base : int'($urandom));
    if (len == 0) begin
      check("load0_done", done_o, 1'b1);
      check("load0_idle", instr_ready_o, 1'b1);
      check("load0_no_wr_ready", wr_ready_o, 1'b0);
      tick();
      check("load0_done_pulse", done_o, 1'b0);
      return;
    end
    check("load_entered", wr_ready_o, 1'b1);
    for (int i = 0; i < len; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        wr_en_i = 1'b0;
        tick();
        check("load_gap_no_done", done_o, 1'b0);
      end
      d = (fixed_q.size() > 0) ? fixed_q.pop_front() : rand_word();
      wr_data_i = d;
      wr_en_i   = 1'b1;
      check("load_wr_ready", wr_ready_o, 1'b1);
      tick();
      a = (base + wp[region]) & (DEPTH - 1);
      mem_m[a] = d;
      mem_v[a] = 1'b1;
      wp[region] = (wp[region] + 1) % DEPTH;
      if (i < len - 1) check("load_mid_no_done", done_o, 1'b0);
    end
    wr_en_i   = 1'b0;
    wr_data_i = rand_word();
    check("load_done", done_o, 1'b1);
    check("load_back_idle", instr_ready_o, 1'b1);
    check("load_wr_ready_low", wr_ready_o, 1'b0);
    tick();
    check("load_done_one_cycle", done_o, 1'b0);
  endtask

  task automatic do_read(input int len, input int abase);
    logic [127:0] last;
    bit last_v;
    int a;
    last = '0;
    last_v = 1'b0;
    issue(4'd5, len, $urandom, abase, $urandom);
    if (len == 0) begin
      check("read0_done", done_o, 1'b1);
      check("read0_no_valid", rd_data_valid_o, 1'b0);
      tick();
      check("read0_done_pulse", done_o, 1'b0);
      return;
    end
    check("read_issue_cycle_no_valid", rd_data_valid_o, 1'b0);
    check("read_issue_cycle_no_done", done_o, 1'b0);
    for (int i = 0; i < len; i++) begin
      tick();
      a = (abase + rdp) & (DEPTH - 1);
      check("read_valid", rd_data_valid_o, 1'b1);
      if (mem_v[a]) check("read_data", rd_data_o, mem_m[a]);
      last = mem_m[a];
      last_v = mem_v[a];
      rdp = (rdp + 1) % DEPTH;
      check("read_done_on_last", done_o, (i == len - 1));
    end
    tick();
    check("read_valid_drops", rd_data_valid_o, 1'b0);
    if (last_v) check("read_data_holds", rd_data_o, last);
    check("read_done_clear", done_o, 1'b0);
    check("read_back_idle", instr_ready_o, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] w0, w1, w2, w3, wn;
    for (int i = 0; i < DEPTH; i++) mem_v[i] = 1'b0;
    wp[0] = 0; wp[1] = 0; wp[2] = 0; rdp = 0;
    rst = 1'b1;
    instr_i = 4'd0; instr_valid_i = 1'b0; instr_len_i = 16'd0;
    weight_start_addr_i = '0; activation_start_addr_i = '0; output_start_addr_i = '0;
    wr_data_i = '0; wr_en_i = 1'b0;

    // Reset values
    #12;
    check("rst_wr_ready", wr_ready_o, 1'b0);
    check("rst_rd_valid", rd_data_valid_o, 1'b0);
    check("rst_rd_data", rd_data_o, 128'd0);
    check("rst_done", done_o, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_instr_ready", instr_ready_o, 1'b1);

    // LOAD_WEIGHT len=3 at base 10, read back through the activation port
    pointer_reset();
    do_load(0, 3, 10, 1'b0);
    pointer_reset();
    do_read(3, 10);

    // LOAD_ACTIVATION len=4 at base 62 wraps to 0,1
    pointer_reset();
    for (int i = 1; i <= 4; i++) fixed_q.push_back(128'(i));
    do_load(1, 4, 62, 1'b0);
    do_read(4, 62);

    // wr_en held in IDLE is ignored, then LOAD_OUTPUT len=1 at base 20
    pointer_reset();
    wr_data_i = 128'hdead_beef;
    wr_en_i   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("idle_wr_ready_low", wr_ready_o, 1'b0);
      tick();
    end
    do_load(2, 1, 20, 1'b0);
    pointer_reset();
    do_read(1, 20);

    // Two back-to-back LOAD_WEIGHT len=2 append, then pointer reset overwrites 0
    pointer_reset();
    w0 = rand_word(); w1 = rand_word(); w2 = rand_word(); w3 = rand_word();
    fixed_q.push_back(w0); fixed_q.push_back(w1);
    do_load(0, 2, 0, 1'b0);
    fixed_q.push_back(w2); fixed_q.push_back(w3);
    do_load(0, 2, 0, 1'b0);
    check("append_model_w3", mem_m[3], w3);
    pointer_reset();
    do_read(4, 0);
    pointer_reset();
    wn = rand_word();
    fixed_q.push_back(wn);
    do_load(0, 1, 0, 1'b0);
    check("overwrite_model_w0", mem_m[0], wn);
    pointer_reset();
    do_read(4, 0);

    // Undefined opcode 9 and zero-length LOAD
    issue(4'd9, 3, 0, 0, 0);
    check("op9_no_done", done_o, 1'b0);
    check("op9_idle", instr_ready_o, 1'b1);
    check("op9_no_wr_ready", wr_ready_o, 1'b0);
    tick();
    check("op9_still_no_done", done_o, 1'b0);
    do_load(0, 0, 0, 1'b0);
    do_read(0, 0);
    pointer_reset();
    do_read(4, 0);

    // Randomized: fill the whole buffer, then mixed loads and reads
    pointer_reset();
    do_load(1, DEPTH, int'($urandom), 1'b1);
    for (int it = 0; it < 12; it++) begin
      if ($urandom_range(0, 1) == 0)
        do_load($urandom_range(0, 2), $urandom_range(1, 8), int'($urandom), 1'b1);
      else
        do_read($urandom_range(1, 10), int'($urandom));
    end

    // Reset in the middle of READ len=8 after three valid words
    pointer_reset();
    issue(4'd5, 8, 0, 7, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("midread_valid", rd_data_valid_o, 1'b1);
      check("midread_data", rd_data_o, mem_m[(7 + i) & (DEPTH - 1)]);
    end
    rst = 1'b1;
    #1;
    check("midread_valid_drops", rd_data_valid_o, 1'b0);
    check("midread_no_done", done_o, 1'b0);
    check("midread_rd_data_cleared", rd_data_o, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midread_ready_after_rst", instr_ready_o, 1'b1);
    check("midread_no_done_after_rst", done_o, 1'b0);
    wp[0] = 0; wp[1] = 0; wp[2] = 0; rdp = 0;
    // Storage survives reset; read pointer restarts at 0
    do_read(4, 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/global_buffer_bank.md
GLOBAL_BUFFER_BANK -- requirements
Module: global_buffer_bank

Interface
REQ-001: Parameter DATA_SIZE, 8, bits per element.
REQ-002: Parameter INTERFACE_DEPTH, 16, elements per word; IW = DATA_SIZE*INTERFACE_DEPTH = 128.
REQ-003: Parameter BUF_DEPTH, 64, storage words (power of two); AW = clog2(BUF_DEPTH).
REQ-004: Parameter ADDR_WIDTH, 32, width of region base-address inputs.
REQ-005: clk  input  1  single clock; all state updates on posedge clk.
REQ-006: rst  input  1  asynchronous, active-high reset.
REQ-007: instr_i  input  4  opcode, global_buffer_instruction_t encoding (NOP=0, POINTER_RESET=1, LOAD_WEIGHT=2, LOAD_ACTIVATION=3, LOAD_OUTPUT=4, READ_ACTIVATION=5).
REQ-008: instr_valid_i  input  1  opcode/length valid.
REQ-009: instr_len_i  input  16  word count of LOAD/READ instruction.
REQ-010: instr_ready_o  output  1  block accepts an instruction.
REQ-011: weight_start_addr_i, activation_start_addr_i, output_start_addr_i  input  ADDR_WIDTH each  region base addresses (word units); only low AW bits used.
REQ-012: wr_data_i  input  IW  write word (bufferSide wr_data).
REQ-013: wr_en_i  input  1  write request, held until accepted.
REQ-014: wr_ready_o  output  1  write accepted on posedge where wr_en_i & wr_ready_o.
REQ-015: rd_data_o  output  IW  read word (bufferSide rd_data).
REQ-016: rd_data_valid_o  output  1  rd_data_o valid this cycle.
REQ-017: done_o  output  1  one-cycle pulse when a LOAD/READ instruction completes.

Function
REQ-018: FSM states IDLE, LOAD, READ; instr_ready_o = (state==IDLE).
REQ-019: Instruction accepted on posedge with instr_valid_i & instr_ready_o; base, length, target region latched then; later base-input changes ignored until next instruction.
REQ-020: NOP and undefined opcodes (6-15): no effect, remain IDLE, no done_o.
REQ-021: POINTER_RESET: all three region offsets (w_ptr, a_ptr, o_ptr, AW bits) and a_rd_ptr cleared next cycle; remain IDLE; no done_o.
REQ-022: LOAD_*: go to LOAD with count = instr_len_i; wr_ready_o = 1 only in LOAD.
REQ-023: Each accepted write stores wr_data_i at mem[(base + region_ptr) mod BUF_DEPTH], increments region_ptr mod BUF_DEPTH, decrements count.
REQ-024: On acceptance of the final word (count==1): return IDLE next cycle, done_o pulses that next cycle.
REQ-025: Region offsets persist across instructions; successive LOADs to the same region append.
REQ-026: READ_ACTIVATION: go to READ; each cycle issue read of mem[(activation base + a_rd_ptr) mod BUF_DEPTH], increment a_rd_ptr; rd_data_valid_o/rd_data_o appear exactly 1 cycle after issue; no backpressure.
REQ-027: READ issues exactly instr_len_i consecutive reads, then IDLE; done_o coincides with final rd_data_valid_o.
REQ-028: instr_len_i==0 for LOAD/READ: no access, stay IDLE, done_o pulses next cycle.
REQ-029: Address arithmetic truncated to AW bits; wrap-around silent, overwrites allowed.
REQ-030: wr_en_i outside LOAD ignored (no write, no ready).
REQ-031: Read of a word during a same-cycle write to the same address returns old data.
REQ-032: rd_data_o holds last value when rd_data_valid_o low.

Reset
REQ-033: rst high asynchronously forces IDLE, all pointers and counters 0, instr_ready_o=1 after release, wr_ready_o=0, rd_data_valid_o=0, rd_data_o=0, done_o=0.
REQ-034: Storage array not reset; reset mid-LOAD/READ aborts instruction with no done_o; partially written words retained.

Verification
REQ-035: Reset, POINTER_RESET, LOAD_WEIGHT len=3 base=10, data A,B,C -> mem[10..12]=A,B,C, done_o one cycle after C accepted.
REQ-036: LOAD_ACTIVATION len=4 base=62, data 1..4 -> mem[62],[63],[0],[1]=1..4 (wrap); READ_ACTIVATION len=4 -> rd_data_valid_o 4 consecutive cycles, data 1,2,3,4, first one cycle after acceptance+1.
REQ-037: wr_en_i held 5 cycles in IDLE, then LOAD_OUTPUT len=1 -> no write during IDLE; single write at output base when LOAD entered.
REQ-038: Two LOAD_WEIGHT len=2 back to back, base=0 -> words at 0,1,2,3; POINTER_RESET then LOAD len=1 -> overwrites address 0.
REQ-039: rst asserted mid-READ len=8 after 3 valid words -> rd_data_valid_o drops immediately, no done_o, instr_ready_o high after release.
REQ-040: Opcode 9 and LOAD len=0 -> no memory change; done_o only for len=0 case.
